// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, sample layout, sequencer state
// encoding and the bit-reversal helper used for output reordering.
package fft_pkg;

  localparam int N_SAMPLES = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;

  // One complex sample; re occupies the upper half of the RAM word.
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } sample_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // Reverse the bit order of a sample index (natural -> FFT RAM order).
  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] idx);
    logic [ADDR_W-1:0] rev;
    for (int i = 0; i < ADDR_W; i++) begin
      rev[i] = idx[ADDR_W-1-i];
    end
    return rev;
  endfunction

endpackage

// File: rtl/out_skid_fifo.sv
// Two-entry skid FIFO holding RAM read data until the consumer accepts it.
// Head data is read straight from storage so it stays put while stalled.
module out_skid_fifo
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_reg [2];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;
  logic              do_push;
  logic              do_pop;

  // Pops only when data is present; a push into a full FIFO is only taken
  // when the head leaves in the same cycle.
  assign do_pop  = pop && (count_reg != 2'd0);
  assign do_push = push && ((count_reg != 2'd2) || do_pop);

  assign dout  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

  // Storage, pointers and occupancy; flush empties and zeroes everything.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= din;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fft_output_sequencer.sv
// Unloads one finished FFT frame from the result RAM in natural order:
// reads are issued at bit-reversed addresses, returned data is parked in a
// 2-entry skid FIFO and streamed out on a valid/ready port.
module fft_output_sequencer
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              fft_done,
  input  logic              clear,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              output_done,
  output logic [ADDR_W:0]   samples_out_count
);

  localparam logic [ADDR_W:0] N_FULL = (ADDR_W+1)'(N_SAMPLES);
  localparam logic [ADDR_W:0] N_LAST = (ADDR_W+1)'(N_SAMPLES - 1);
  localparam logic [ADDR_W:0] ONE    = (ADDR_W+1)'(1);

  seq_state_t      state_reg;
  logic [ADDR_W:0] rd_idx_reg;
  logic [ADDR_W:0] out_idx_reg;
  logic            inflight_reg;
  logic [1:0]      fifo_cnt;
  logic            pop;
  logic            push;
  logic [2:0]      occupancy;

  assign pop  = out_valid && out_ready;
  // Data returning in the cycle clear is seen belongs to the aborted frame.
  assign push = inflight_reg && !clear;

  // Slots committed after this cycle: buffered + returning - leaving.
  // pop implies fifo_cnt >= 1, so this never underflows.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight_reg} - {2'b00, pop};

  assign mem_ren   = (state_reg == ST_RUN) && (rd_idx_reg < N_FULL) && (occupancy < 3'd2);
  assign mem_raddr = bitrev(rd_idx_reg[ADDR_W-1:0]);

  assign out_valid         = (fifo_cnt != 2'd0);
  assign busy              = (state_reg == ST_RUN);
  assign output_done       = (state_reg == ST_DONE);
  assign samples_out_count = out_idx_reg;

  out_skid_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (clear),
    .din   (mem_rdata),
    .dout  (out_data),
    .count (fifo_cnt)
  );

  // Frame FSM with read/accept counters; reset and clear abort identically.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_reg    <= ST_IDLE;
      rd_idx_reg   <= '0;
      out_idx_reg  <= '0;
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= mem_ren;
      if (mem_ren) begin
        rd_idx_reg <= rd_idx_reg + ONE;
      end
      if (pop) begin
        out_idx_reg <= out_idx_reg + ONE;
      end
      case (state_reg)
        ST_IDLE: begin
          if (fft_done) begin
            state_reg   <= ST_RUN;
            rd_idx_reg  <= '0;
            out_idx_reg <= '0;
          end
        end
        ST_RUN: begin
          if (pop && (out_idx_reg == N_LAST)) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_reg   <= ST_IDLE;
          rd_idx_reg  <= '0;
          out_idx_reg <= '0;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
